// File: rtl/bus_seq_pkg.sv
// Shared definitions for the external memory bus sequencer: FSM state and
// grant encodings.
package bus_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_LATCH  = 3'd2,
    S_STROBE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    GNT_ROM = 1'b0,
    GNT_RAM = 1'b1
  } grant_t;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/bus_seq_arb.sv
// Two-input round-robin arbiter; last_grant only advances when the
// sequencer is idle and actually accepts a winner.
module bus_seq_arb
  import bus_seq_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   eval,
  input  logic   rom_req,
  input  logic   ram_req,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_q;

  always_comb begin
    gnt_valid = rom_req | ram_req;
    if (rom_req && ram_req) begin
      gnt = (last_q == GNT_ROM) ? GNT_RAM : GNT_ROM;
    end else if (ram_req) begin
      gnt = GNT_RAM;
    end else begin
      gnt = GNT_ROM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= GNT_ROM;
    end else if (eval && gnt_valid) begin
      last_q <= gnt;
    end
  end

endmodule

// File: rtl/bus_seq.sv
// External memory bus sequencer: one multiplexed P0/P2 cycle at a time
// (ALE, latch, strobe, done) for code fetch (PSEN) and MOVX (RD/WR).
module bus_seq
  import bus_seq_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              bus_seq_clk_i,
  input  logic              bus_seq_reset_i,
  input  logic              bus_seq_rom_req_i,
  input  logic [ADDR_W-1:0] bus_seq_rom_addr_i,
  output logic              bus_seq_rom_ack_o,
  output logic [DATA_W-1:0] bus_seq_rom_data_o,
  input  logic              bus_seq_ram_req_i,
  input  logic              bus_seq_ram_we_i,
  input  logic [ADDR_W-1:0] bus_seq_ram_addr_i,
  input  logic [DATA_W-1:0] bus_seq_ram_wdata_i,
  output logic              bus_seq_ram_ack_o,
  output logic [DATA_W-1:0] bus_seq_ram_rdata_o,
  input  logic [7:0]        bus_seq_p0_i,
  output logic [7:0]        bus_seq_p0_o,
  output logic [7:0]        bus_seq_p0en_o,
  output logic [7:0]        bus_seq_p2_o,
  output logic [7:0]        bus_seq_p2en_o,
  output logic              bus_seq_ale_o,
  output logic              bus_seq_psen_b_o,
  output logic              bus_seq_rd_b_o,
  output logic              bus_seq_wr_b_o,
  output logic              bus_seq_busy_o
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  grant_t             gnt_q, txn_gnt, arb_gnt;
  logic               we_q, txn_we;
  logic [ADDR_W-1:0]  addr_q, txn_addr;
  logic [DATA_W-1:0]  wdata_q, txn_wdata;
  logic               arb_valid, arb_eval, capture, sample_rd;

  logic               ale_d, psen_d, rd_d, wr_d, rom_ack_d, ram_ack_d;
  logic [7:0]         p0_d, p0en_d, p2_d, p2en_d;

  bus_seq_arb u_arb (
    .clk       (bus_seq_clk_i),
    .rst       (bus_seq_reset_i),
    .eval      (arb_eval),
    .rom_req   (bus_seq_rom_req_i),
    .ram_req   (bus_seq_ram_req_i),
    .gnt_valid (arb_valid),
    .gnt       (arb_gnt)
  );

  // Pins are registered from the next state, so in IDLE the transaction
  // fields come straight from the winner rather than the capture registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arb_eval  = (state_q == S_IDLE);
    capture   = 1'b0;
    txn_gnt   = gnt_q;
    txn_we    = we_q;
    txn_addr  = addr_q;
    txn_wdata = wdata_q;
    sample_rd = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_valid) begin
          state_d   = S_ADDR;
          capture   = 1'b1;
          txn_gnt   = arb_gnt;
          txn_we    = (arb_gnt == GNT_RAM) && bus_seq_ram_we_i;
          txn_addr  = (arb_gnt == GNT_RAM) ? bus_seq_ram_addr_i : bus_seq_rom_addr_i;
          txn_wdata = bus_seq_ram_wdata_i;
        end
      end
      S_ADDR:  state_d = S_LATCH;
      S_LATCH: begin
        state_d = S_STROBE;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          sample_rd = !we_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ale_d     = 1'b0;
    psen_d    = 1'b1;
    rd_d      = 1'b1;
    wr_d      = 1'b1;
    rom_ack_d = 1'b0;
    ram_ack_d = 1'b0;
    p0_d      = '0;
    p0en_d    = '0;
    p2_d      = '0;
    p2en_d    = '0;

    case (state_d)
      S_ADDR, S_LATCH: begin
        ale_d  = (state_d == S_ADDR);
        p0_d   = txn_addr[7:0];
        p0en_d = '1;
        p2_d   = txn_addr[15:8];
        p2en_d = '1;
      end
      S_STROBE: begin
        p2_d   = txn_addr[15:8];
        p2en_d = '1;
        if (txn_gnt == GNT_ROM) begin
          psen_d = 1'b0;
        end else if (txn_we) begin
          wr_d   = 1'b0;
          p0_d   = 8'(txn_wdata);
          p0en_d = '1;
        end else begin
          rd_d = 1'b0;
        end
      end
      S_DONE: begin
        rom_ack_d = (txn_gnt == GNT_ROM);
        ram_ack_d = (txn_gnt == GNT_RAM);
      end
      default: ;
    endcase
  end

  always_ff @(posedge bus_seq_clk_i or posedge bus_seq_reset_i) begin
    if (bus_seq_reset_i) begin
      state_q             <= S_IDLE;
      cnt_q               <= '0;
      gnt_q               <= GNT_ROM;
      we_q                <= 1'b0;
      addr_q              <= '0;
      wdata_q             <= '0;
      bus_seq_ale_o       <= 1'b0;
      bus_seq_psen_b_o    <= 1'b1;
      bus_seq_rd_b_o      <= 1'b1;
      bus_seq_wr_b_o      <= 1'b1;
      bus_seq_p0_o        <= '0;
      bus_seq_p0en_o      <= '0;
      bus_seq_p2_o        <= '0;
      bus_seq_p2en_o      <= '0;
      bus_seq_rom_ack_o   <= 1'b0;
      bus_seq_ram_ack_o   <= 1'b0;
      bus_seq_rom_data_o  <= '0;
      bus_seq_ram_rdata_o <= '0;
      bus_seq_busy_o      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        gnt_q   <= txn_gnt;
        we_q    <= txn_we;
        addr_q  <= txn_addr;
        wdata_q <= txn_wdata;
      end
      bus_seq_ale_o     <= ale_d;
      bus_seq_psen_b_o  <= psen_d;
      bus_seq_rd_b_o    <= rd_d;
      bus_seq_wr_b_o    <= wr_d;
      bus_seq_p0_o      <= p0_d;
      bus_seq_p0en_o    <= p0en_d;
      bus_seq_p2_o      <= p2_d;
      bus_seq_p2en_o    <= p2en_d;
      bus_seq_rom_ack_o <= rom_ack_d;
      bus_seq_ram_ack_o <= ram_ack_d;
      bus_seq_busy_o    <= (state_d != S_IDLE);
      if (sample_rd) begin
        if (gnt_q == GNT_ROM) begin
          bus_seq_rom_data_o <= DATA_W'(bus_seq_p0_i);
        end else begin
          bus_seq_ram_rdata_o <= DATA_W'(bus_seq_p0_i);
        end
      end
    end
  end

endmodule
